// File: rtl/data_mem_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_mem_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

  // A misaligned read (when the alignment check is built in) returns this bit replicated.
  localparam logic MISALIGN_FILL_BIT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester A/B handshakes plus the single memory port, bundled for the arbiter.
interface data_mem_arbiter_if
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              a_req, a_we, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;

  logic              b_req, b_we, b_gnt, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wrt_data, mem_read_data;
  logic              mem_write, mem_read;

  // master: requesters plus the memory model; slave: the arbiter
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_read_data,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    input  mem_address, mem_wrt_data, mem_write, mem_read
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_read_data,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    output mem_address, mem_wrt_data, mem_write, mem_read
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer remembers the last winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last_b;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_b ? 2'b01 : 2'b10;
  end

  // Reset value "last was B" gives A priority on the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             last_b <= 1'b1;
    else if (en && |gnt)    last_b <= gnt[1];
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Two requesters sharing one data memory port; IDLE -> ACCESS -> (RESP) per transaction.
// Optional DATA_MEM_ARB_ALIGN_CHECK_EN: misaligned accesses never reach memory.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_arbiter_if.slave bus
);
  arb_state_e        state, state_n;
  owner_e            owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, a_rdata_q, b_rdata_q, rd_val;
  logic [1:0]        arb_gnt, gnt;
  logic              idle, aligned;

  assign idle = (state == S_IDLE);

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.b_req, bus.a_req}),
    .en    (idle),
    .gnt   (arb_gnt)
  );

  // Grant is only meaningful in IDLE and is forced low while reset is held.
  assign gnt = arb_gnt & {2{idle & reset}};

`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
  assign aligned = (addr_q[2:0] == 3'b000);
`else
  assign aligned = 1'b1;
`endif

  assign rd_val = aligned ? bus.mem_read_data : {DATA_W{MISALIGN_FILL_BIT}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (|gnt) state_n = S_ACCESS;
      S_ACCESS: state_n = we_q ? S_IDLE : S_RESP;
      S_RESP:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // addr_q/wdata_q only change on a grant, so they double as the held memory bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q   <= OWN_A;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (idle && |gnt) begin
        owner_q <= gnt[1] ? OWN_B : OWN_A;
        we_q    <= gnt[1] ? bus.b_we    : bus.a_we;
        addr_q  <= gnt[1] ? bus.b_addr  : bus.a_addr;
        wdata_q <= gnt[1] ? bus.b_wdata : bus.a_wdata;
      end
      if (state == S_ACCESS && !we_q) begin
        if (owner_q == OWN_B) b_rdata_q <= rd_val;
        else                  a_rdata_q <= rd_val;
      end
    end
  end

  assign bus.a_gnt        = gnt[0];
  assign bus.b_gnt        = gnt[1];
  assign bus.a_rvalid     = (state == S_RESP) && (owner_q == OWN_A);
  assign bus.b_rvalid     = (state == S_RESP) && (owner_q == OWN_B);
  assign bus.a_rdata      = a_rdata_q;
  assign bus.b_rdata      = b_rdata_q;
  assign bus.mem_address  = addr_q;
  assign bus.mem_wrt_data = wdata_q;
  assign bus.mem_write    = (state == S_ACCESS) &&  we_q && aligned;
  assign bus.mem_read     = (state == S_ACCESS) && !we_q && aligned;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized and directed bench for data_mem_arbiter against a transaction-level model.
module tb_data_mem_arbiter;
  import data_mem_pkg::*;

`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [63:0] env_mem [64];
  logic [63:0] ref_mem [64];

  data_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  data_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory environment: combinational read, write on the clock edge.
  assign bus.mem_read_data = env_mem[bus.mem_address[8:3]];
  always @(posedge clk) if (bus.mem_write) env_mem[bus.mem_address[8:3]] = bus.mem_wrt_data;

  task automatic idle_inputs();
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 reset = 0;
    #3 bus.a_req = 1; bus.b_req = 1;
    #1;
    n_chk++;
    if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.mem_write, bus.mem_read} !== 6'b0)
      $display("FAIL reset_flags: got %b exp 000000", {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.mem_write, bus.mem_read});
    else n_pass++;
    n_chk++;
    if ({bus.a_rdata, bus.b_rdata, bus.mem_address, bus.mem_wrt_data} !== 256'b0)
      $display("FAIL reset_buses: got %h exp 0", {bus.a_rdata, bus.b_rdata, bus.mem_address, bus.mem_wrt_data});
    else n_pass++;
    idle_inputs();
    @(negedge clk) reset = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      n_chk++;
      if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.mem_write, bus.mem_read, bus.a_rdata, bus.b_rdata, bus.mem_address} !== '0)
        $display("FAIL reset_idle cycle %0d: got nonzero outputs flags=%b", c, {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.mem_write, bus.mem_read});
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    logic [63:0] exp_rd;
    exp_rd = ALIGN_EN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd3;
    do_reset();
    tick();
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 64'd4; bus.a_wdata = 64'd3;
    @(negedge clk);
    n_chk++;
    if (bus.a_gnt !== 1'b1) $display("FAIL wr_gnt: got %b exp 1", bus.a_gnt); else n_pass++;
    tick();
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if ({bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_wrt_data} !== {!ALIGN_EN, 1'b0, 64'd4, 64'd3})
      $display("FAIL wr_access: got w=%b r=%b a=%0d d=%0d exp w=%b a=4 d=3", bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_wrt_data, !ALIGN_EN);
    else n_pass++;
    tick();
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 64'd4;
    @(negedge clk);
    n_chk++;
    if ({bus.a_gnt, bus.mem_write} !== 2'b10) $display("FAIL rd_gnt: got gnt=%b w=%b exp gnt=1 w=0", bus.a_gnt, bus.mem_write); else n_pass++;
    tick();
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if ({bus.mem_read, bus.mem_write, bus.a_rvalid} !== {!ALIGN_EN, 2'b00})
      $display("FAIL rd_access: got r=%b w=%b rv=%b exp r=%b w=0 rv=0", bus.mem_read, bus.mem_write, bus.a_rvalid, !ALIGN_EN);
    else n_pass++;
    tick();
    @(negedge clk);
    n_chk++;
    if ({bus.a_rvalid, bus.b_rvalid, bus.a_rdata} !== {2'b10, exp_rd})
      $display("FAIL rd_resp: got rv=%b%b rdata=%h exp rv=10 rdata=%h", bus.a_rvalid, bus.b_rvalid, bus.a_rdata, exp_rd);
    else n_pass++;
    tick();
    @(negedge clk);
    n_chk++;
    if ({bus.a_rvalid, bus.a_rdata} !== {1'b0, exp_rd})
      $display("FAIL rd_hold: got rv=%b rdata=%h exp rv=0 rdata=%h", bus.a_rvalid, bus.a_rdata, exp_rd);
    else n_pass++;
  endtask

  task automatic test_align();
    logic [63:0] exp_rd;
    exp_rd = ALIGN_EN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd3;
    do_reset();
    tick();
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 64'd5;
    @(negedge clk);
    tick();
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if ({bus.mem_read, bus.mem_write, bus.mem_address} !== {!ALIGN_EN, 1'b0, 64'd5})
      $display("FAIL align_access: got r=%b w=%b a=%0d exp r=%b a=5", bus.mem_read, bus.mem_write, bus.mem_address, !ALIGN_EN);
    else n_pass++;
    tick();
    @(negedge clk);
    n_chk++;
    if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, exp_rd})
      $display("FAIL align_resp: got rv=%b rdata=%h exp rv=1 rdata=%h", bus.a_rvalid, bus.a_rdata, exp_rd);
    else n_pass++;
  endtask

  task automatic test_alternate();
    logic [3:0] exp, got;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tick();
      bus.a_req = 1; bus.a_addr = 64'd8;
      bus.b_req = 1; bus.b_addr = 64'd16;
      // Each read occupies 3 cycles; owners alternate A, B, A, B.
      exp = 4'b0;
      if (c % 3 == 0) exp[3 - ((c / 3) % 2)] = 1'b1;
      if (c % 3 == 2) exp[1 - ((c / 3) % 2)] = 1'b1;
      @(negedge clk);
      got = {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid};
      n_chk++;
      if (got !== exp) $display("FAIL alternate cycle %0d: got gnt/rv=%b exp %b", c, got, exp);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_resp_window();
    do_reset();
    tick();
    bus.a_req = 1; bus.a_addr = 64'd8;
    tick();
    bus.a_req = 0;
    tick();
    bus.a_req = 1; bus.b_req = 1; bus.b_addr = 64'd16;
    @(negedge clk);
    n_chk++;
    if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid} !== 3'b001)
      $display("FAIL resp_window_resp: got gnt=%b%b rv=%b exp gnt=00 rv=1", bus.a_gnt, bus.b_gnt, bus.a_rvalid);
    else n_pass++;
    tick();
    @(negedge clk);
    n_chk++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b01)
      $display("FAIL resp_window_idle: got gnt=%b%b exp 01", bus.a_gnt, bus.b_gnt);
    else n_pass++;
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset_abort();
    do_reset();
    tick();
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 64'd16;
    @(negedge clk);
    n_chk++;
    if (bus.b_gnt !== 1'b1) $display("FAIL abort_gnt: got %b exp 1", bus.b_gnt); else n_pass++;
    tick();
    bus.b_req = 0;
    n_chk++;
    if (bus.mem_read !== 1'b1) $display("FAIL abort_in_access: got mem_read=%b exp 1", bus.mem_read); else n_pass++;
    reset = 0;
    #1;
    n_chk++;
    if ({bus.mem_read, bus.b_rvalid} !== 2'b00) $display("FAIL abort_immediate: got r=%b rv=%b exp 00", bus.mem_read, bus.b_rvalid); else n_pass++;
    @(negedge clk) reset = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      n_chk++;
      if ({bus.b_rvalid, bus.b_rdata} !== 65'b0) $display("FAIL abort_no_rvalid cycle %0d: got rv=%b rdata=%h exp 0", c, bus.b_rvalid, bus.b_rdata);
      else n_pass++;
    end
    tick();
    bus.a_req = 1; bus.a_addr = 64'd0; bus.b_req = 1; bus.b_addr = 64'd8;
    @(negedge clk);
    n_chk++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b10) $display("FAIL abort_next_a: got gnt=%b%b exp 10", bus.a_gnt, bus.b_gnt); else n_pass++;
    // A now owns the pointer; a reset must still hand priority back to A.
    tick();
    idle_inputs();
    reset = 0;
    #2 reset = 1;
    tick();
    bus.a_req = 1; bus.b_req = 1; bus.b_addr = 64'd8;
    @(negedge clk);
    n_chk++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b10) $display("FAIL abort_ptr_reset: got gnt=%b%b exp 10", bus.a_gnt, bus.b_gnt); else n_pass++;
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_random();
    int          t;
    bit          own_b, own_we, last_b, win;
    logic [63:0] own_addr, own_wd, maddr, mwd;
    logic [63:0] exp_rd [2];
    bit          pend [2];
    bit          pwe [2];
    logic [63:0] paddr [2];
    logic [63:0] pwd [2];
    logic [1:0]  exp_g;
    logic [5:0]  got, exp;
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = {$urandom, $urandom};
      ref_mem[i] = env_mem[i];
    end
    do_reset();
    t = -1; last_b = 1; own_b = 0; own_we = 0; own_addr = '0; own_wd = '0;
    maddr = '0; mwd = '0; exp_rd[0] = '0; exp_rd[1] = '0;
    for (int p = 0; p < 2; p++) begin pend[p] = 0; pwe[p] = 0; paddr[p] = '0; pwd[p] = '0; end
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && $urandom_range(0, 15) == 0) pend[p] = 0;
        else if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]  = 1;
          pwe[p]   = 1'($urandom_range(0, 1));
          paddr[p] = {55'd0, 6'($urandom_range(0, 63)), 3'b000};
          pwd[p]   = {$urandom, $urandom};
        end
      end
      bus.a_req = pend[0]; bus.a_we = pwe[0]; bus.a_addr = paddr[0]; bus.a_wdata = pwd[0];
      bus.b_req = pend[1]; bus.b_we = pwe[1]; bus.b_addr = paddr[1]; bus.b_wdata = pwd[1];
      // Writes hold the port 2 cycles from grant, reads 3.
      exp_g = 2'b00;
      if (t < 0 || (own_we && t >= 2) || (!own_we && t >= 3)) begin
        t = -1;
        if (pend[0] || pend[1]) begin
          win = (pend[0] && pend[1]) ? !last_b : pend[1];
          exp_g[win] = 1'b1;
          last_b = win; own_b = win; own_we = pwe[win];
          own_addr = paddr[win]; own_wd = pwd[win];
          pend[win] = 0;
          t = 0;
        end
      end
      if (t == 1) begin maddr = own_addr; mwd = own_wd; end
      exp = {exp_g[0], exp_g[1], (t == 2 && !own_we && !own_b), (t == 2 && !own_we && own_b),
             (t == 1 && own_we), (t == 1 && !own_we)};
      @(negedge clk);
      got = {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.mem_write, bus.mem_read};
      n_chk++;
      if (got !== exp) $display("FAIL rand_ctrl cycle %0d: got gnt/rv/w/r=%b exp %b", c, got, exp);
      else n_pass++;
      n_chk++;
      if ({bus.a_rdata, bus.b_rdata} !== {exp_rd[0], exp_rd[1]})
        $display("FAIL rand_rdata cycle %0d: got a=%h b=%h exp a=%h b=%h", c, bus.a_rdata, bus.b_rdata, exp_rd[0], exp_rd[1]);
      else n_pass++;
      n_chk++;
      if ({bus.mem_address, bus.mem_wrt_data} !== {maddr, mwd})
        $display("FAIL rand_membus cycle %0d: got a=%h d=%h exp a=%h d=%h", c, bus.mem_address, bus.mem_wrt_data, maddr, mwd);
      else n_pass++;
      if (t == 1) begin
        if (own_we) ref_mem[own_addr[8:3]] = own_wd;
        else        exp_rd[own_b] = ref_mem[own_addr[8:3]];
      end
      if (t >= 0) t++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 64; i++) env_mem[i] = {$urandom, $urandom};
    test_reset();
    test_write_read();
    test_align();
    test_alternate();
    test_resp_window();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
